gcd_job_sequencer: RTL and testbench

Initiator-side front end for the binary GCD engine. Accepts operand pairs on a valid/ready input channel and drives the engine's operand, reset and done interface. Returns each result, or a timeout error, on a valid/ready output channel. It sits between the system bus/testbench and the gcd datapath, replacing ad-hoc reset pulsing with a single-outstanding-job handshake.

---
 rtl/gcd_pkg.sv | 27 ++
 rtl/gcd_seq_timer.sv | 26 ++
 rtl/gcd_job_sequencer.sv | 166 ++++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared state encoding, default width and clog2 helper for the GCD job sequencer.
package gcd_pkg;

  localparam int GCD_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR,
    RUN   = ST_RUN,
    RESP  = ST_RESP
  } seq_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gcd_seq_timer.sv
// Up-counter with clear, enable and terminal-count flag; shared by the CLEAR hold and RUN timeout.
module gcd_seq_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] tc_val,
  output logic [TW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !(&count)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Single-outstanding-job front end for the binary GCD engine.
// Optional per-job statistics counters are built when GCD_SEQ_STATS_EN is defined.
//
// state | meaning
// IDLE  | ready for an operand pair, engine held in reset
// CLEAR | new operands stable, engine reset held for RST_CYCLES
// RUN   | engine released, waiting for done or timeout
// RESP  | result/error presented until the consumer accepts it
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH      = GCD_WIDTH,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [WIDTH-1:0] eng_in1,
  output logic [WIDTH-1:0] eng_in2,
  output logic             eng_reset,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_out,
  output logic [15:0]      stat_jobs,
  output logic [WIDTH-1:0] stat_cycles
);

  localparam int TW = clog2((TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES) + 1;

  seq_state_e    state, state_nxt;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_count, tmr_tc_val;
  logic          accept, bypass, run_exit;

  assign tmr_tc_val = (state == RUN) ? TW'(TIMEOUT - 1) : TW'(RST_CYCLES - 1);

  gcd_seq_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tc_val (tmr_tc_val),
    .count  (tmr_count),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    accept    = 1'b0;
    bypass    = 1'b0;
    run_exit  = 1'b0;
    case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_a == '0 || in_b == '0) begin
            bypass    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = CLEAR;
          end
        end
      end
      CLEAR: begin
        if (tmr_tc) begin
          tmr_clr   = 1'b1;
          state_nxt = RUN;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RUN: begin
        // done is checked first so a done on the last allowed cycle is not an error
        if (eng_done || tmr_tc) begin
          run_exit  = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = RESP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign eng_reset = (state != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_in1   <= '0;
      eng_in2   <= '0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        eng_in1 <= in_a;
        eng_in2 <= in_b;
      end
      if (bypass) begin
        out_gcd   <= in_a | in_b;
        out_err   <= 1'b0;
        out_valid <= 1'b1;
      end else if (run_exit) begin
        out_valid <= 1'b1;
        if (eng_done) begin
          out_gcd <= eng_out;
          out_err <= 1'b0;
        end else begin
          out_gcd <= '0;
          out_err <= 1'b1;
        end
      end else if (state == RESP && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef GCD_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_jobs   <= '0;
      stat_cycles <= '0;
    end else begin
      if (out_valid && out_ready) begin
        stat_jobs <= stat_jobs + 16'd1;
      end
      if (bypass) begin
        stat_cycles <= '0;
      end else if (run_exit) begin
        stat_cycles <= WIDTH'(tmr_count) + WIDTH'(1);
      end
    end
  end
`else
  logic unused_tmr_count;
  assign unused_tmr_count = ^tmr_count;
  assign stat_jobs        = '0;
  assign stat_cycles      = '0;
`endif

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Self-checking bench for gcd_job_sequencer with a behavioural engine and job-level reference model.
module tb_gcd_job_sequencer;

  localparam int WIDTH      = 32;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic [WIDTH-1:0] eng_in1;
  logic [WIDTH-1:0] eng_in2;
  logic             eng_reset;
  logic             eng_done;
  logic [WIDTH-1:0] eng_out;
  logic [15:0]      stat_jobs;
  logic [WIDTH-1:0] stat_cycles;

  int total = 0;
  int bad   = 0;
  int eng_delay = 1000;
  int eng_cnt   = 0;
  int run_cnt   = 0;
  int exp_jobs  = 0;
  int exp_cycles = 0;

  gcd_job_sequencer #(
    .WIDTH      (WIDTH),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .eng_in1     (eng_in1),
    .eng_in2     (eng_in2),
    .eng_reset   (eng_reset),
    .eng_done    (eng_done),
    .eng_out     (eng_out),
    .stat_jobs   (stat_jobs),
    .stat_cycles (stat_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: raises done in the eng_delay-th cycle after its reset is released.
  always @(posedge clk) begin
    if (eng_reset) eng_cnt <= 0;
    else           eng_cnt <= eng_cnt + 1;
  end

  always_comb begin
    eng_done = 1'b0;
    eng_out  = 32'hdead_beef;
    if (!eng_reset && eng_cnt == eng_delay - 1) begin
      eng_done = 1'b1;
      eng_out  = ref_gcd(eng_in1, eng_in2);
    end
  end

  always @(negedge clk) begin
    if (!eng_reset) run_cnt <= run_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef GCD_SEQ_STATS_EN
    chk("stat_jobs", 64'(stat_jobs), 64'(exp_jobs & 16'hffff));
    chk("stat_cycles", 64'(stat_cycles), 64'(exp_cycles));
`else
    chk("stat_jobs_off", 64'(stat_jobs), 64'd0);
    chk("stat_cycles_off", 64'(stat_cycles), 64'd0);
`endif
  endtask

  task automatic do_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int delay, input int hold);
    logic [WIDTH-1:0] e_gcd;
    logic             e_err;
    int               e_run, e_lat, lat, wait_cnt, run_base;
    if (a == 0 || b == 0) begin
      e_gcd = a | b; e_err = 1'b0; e_run = 0;
    end else if (delay <= TIMEOUT) begin
      e_gcd = ref_gcd(a, b); e_err = 1'b0; e_run = delay;
    end else begin
      e_gcd = '0; e_err = 1'b1; e_run = TIMEOUT;
    end
    e_lat = (a == 0 || b == 0) ? 1 : 1 + RST_CYCLES + e_run;
    eng_delay = delay;

    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("in_ready_before_job", 64'(in_ready), 64'd1);

    in_a = a; in_b = b; in_valid = 1'b1;
    run_base = run_cnt;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    chk("eng_in1_latched", 64'(eng_in1), 64'(a));
    chk("eng_in2_latched", 64'(eng_in2), 64'(b));

    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(e_lat));
    chk("out_gcd", 64'(out_gcd), 64'(e_gcd));
    chk("out_err", 64'(out_err), 64'(e_err));
    chk("run_cycles", 64'(run_cnt - run_base), 64'(e_run));

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = 32'd99; in_b = 32'd77;
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_gcd", 64'(out_gcd), 64'(e_gcd));
      chk("hold_out_err", 64'(out_err), 64'(e_err));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_eng_in1", 64'(eng_in1), 64'(a));
      chk("hold_eng_reset", 64'(eng_reset), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_cleared", 64'(out_valid), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'd1);
    chk("eng_in2_stable", 64'(eng_in2), 64'(b));
    exp_jobs   = exp_jobs + 1;
    exp_cycles = e_run;
    chk_stats();
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int f;
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_gcd", 64'(out_gcd), 64'd0);
    chk("rst_eng_in1", 64'(eng_in1), 64'd0);
    chk("rst_eng_in2", 64'(eng_in2), 64'd0);
    chk("rst_eng_reset", 64'(eng_reset), 64'd1);
    chk_stats();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_job(32'd48, 32'd18, 10, 0);
    do_job(32'd0, 32'd35, 10, 0);
    do_job(32'd0, 32'd0, 10, 1);
    do_job(32'd7, 32'd5, 1000, 0);
    do_job(32'd21, 32'd14, 5, 0);
    do_job(32'd48, 32'd18, 3, 5);
    do_job(32'd100, 32'd75, TIMEOUT, 0);
    do_job(32'd100, 32'd75, TIMEOUT + 1, 2);
    do_job(32'd13, 32'd13, 1, 0);

    // Abort mid-RUN with the asynchronous reset.
    eng_delay = 10;
    in_a = 32'd30; in_b = 32'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (RST_CYCLES + 2) @(posedge clk);
    #1;
    chk("mid_run_eng_reset", 64'(eng_reset), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_eng_reset", 64'(eng_reset), 64'd1);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_eng_in1", 64'(eng_in1), 64'd0);
    exp_jobs = 0; exp_cycles = 0;
    chk_stats();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_job(32'd9, 32'd6, 7, 0);

    for (int j = 0; j < 20; j++) begin
      f  = $urandom_range(1, 12);
      ra = 32'($urandom_range(1, 1000) * f);
      rb = 32'($urandom_range(1, 1000) * f);
      if ($urandom_range(0, 5) == 0) ra = '0;
      do_job(ra, rb, $urandom_range(1, 20), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
